// File: rtl/fmul_seq.sv
`default_nettype none
// ============================================================================
// Module   : fmul_seq
// Brief    : Digit-serial MIX floating-point multiplier with byte-wise
//            normalisation, round-half-even and separate over/underflow.
// Revision : 1.0
// ============================================================================
module fmul_seq #(
    parameter int BYTE  = 6,
    parameter int NB    = 4,
    parameter int DIGIT = 3,
    parameter int W     = 1 + BYTE + NB * BYTE
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic [W-1:0] out,
    output logic         busy,
    output logic         done,
    output logic         overflow,
    output logic         underflow
);

    localparam int c_M   = NB * BYTE;
    localparam int c_P   = 2 * c_M;
    localparam int c_CYC = c_M / DIGIT;
    localparam int c_EW  = BYTE + 2;
    localparam int c_CW  = $clog2(c_CYC + 1);

    localparam logic        [c_EW-1:0] c_Q    = c_EW'(2 ** (BYTE - 1));
    localparam logic signed [c_EW-1:0] c_EMAX = c_EW'(2 ** BYTE - 1);
    localparam logic signed [c_EW-1:0] c_ONE  = c_EW'(1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_MUL   = 2'd1;
    localparam logic [1:0] c_NORM  = 2'd2;
    localparam logic [1:0] c_ROUND = 2'd3;

    logic [1:0]              r_state;
    logic                    r_sign;
    logic                    r_zero;
    logic signed [c_EW-1:0]  r_exp;
    logic [c_M-1:0]          r_f1;
    logic [c_M-1:0]          r_f2;
    logic [c_P-1:0]          r_p;
    logic [c_CW-1:0]         r_cnt;

    // Operand exponents, zero-extended so the biased sum cannot wrap.
    logic [c_EW-1:0]         w_e1;
    logic [c_EW-1:0]         w_e2;
    assign w_e1 = {2'b00, in1[W-2 -: BYTE]};
    assign w_e2 = {2'b00, in2[W-2 -: BYTE]};

    logic [DIGIT-1:0]        w_digit;
    logic [c_P-1:0]          w_part;
    logic [c_P-1:0]          w_pmul;
    logic                    w_pmul_zero;
    logic                    w_pmul_top;
    assign w_digit     = r_f1[c_M-1 -: DIGIT];
    assign w_part      = c_P'(w_digit) * c_P'(r_f2);
    assign w_pmul      = (r_p << DIGIT) + w_part;
    assign w_pmul_zero = (w_pmul == '0);
    assign w_pmul_top  = |w_pmul[c_P-1 -: BYTE];

    logic [c_P-1:0]          w_pshift;
    logic                    w_pshift_top;
    assign w_pshift     = r_p << BYTE;
    assign w_pshift_top = |w_pshift[c_P-1 -: BYTE];

    // Round half to even on the upper half of the product.
    logic [c_M-1:0]          w_k;
    logic                    w_g;
    logic                    w_s;
    logic                    w_up;
    logic [c_M:0]            w_sum;
    logic                    w_carry;
    logic [c_M-1:0]          w_kcarry;
    logic [c_M-1:0]          w_kfin;
    logic signed [c_EW-1:0]  w_efin;
    logic                    w_ovf;
    logic                    w_unf;
    assign w_k      = r_p[c_P-1:c_M];
    assign w_g      = r_p[c_M-1];
    assign w_s      = |r_p[c_M-2:0];
    assign w_up     = w_g & (w_s | w_k[0]);
    assign w_sum    = {1'b0, w_k} + {{c_M{1'b0}}, w_up};
    assign w_carry  = w_sum[c_M];
    // A carry out leaves a single leading one; renormalise by one byte.
    assign w_kcarry = {{(BYTE-1){1'b0}}, w_sum[c_M:BYTE]};
    assign w_kfin   = w_carry ? w_kcarry : w_sum[c_M-1:0];
    assign w_efin   = w_carry ? (r_exp + c_ONE) : r_exp;
    assign w_ovf    = (w_efin > c_EMAX);
    assign w_unf    = w_efin[c_EW-1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_sign    <= 1'b0;
            r_zero    <= 1'b0;
            r_exp     <= '0;
            r_f1      <= '0;
            r_f2      <= '0;
            r_p       <= '0;
            r_cnt     <= '0;
            out       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_sign  <= in1[W-1] ^ in2[W-1];
                        r_exp   <= w_e1 + w_e2 - c_Q;
                        r_f1    <= in1[c_M-1:0];
                        r_f2    <= in2[c_M-1:0];
                        r_p     <= '0;
                        r_zero  <= 1'b0;
                        r_cnt   <= c_CW'(c_CYC - 1);
                        busy    <= 1'b1;
                        r_state <= c_MUL;
                    end
                end
                c_MUL: begin
                    r_p   <= w_pmul;
                    r_f1  <= r_f1 << DIGIT;
                    r_cnt <= r_cnt - c_CW'(1);
                    if (r_cnt == '0) begin
                        // Decide on the final product so k=0 costs no cycle.
                        r_zero  <= w_pmul_zero;
                        r_state <= (w_pmul_zero || w_pmul_top) ? c_ROUND : c_NORM;
                    end
                end
                c_NORM: begin
                    r_p   <= w_pshift;
                    r_exp <= r_exp - c_ONE;
                    if (w_pshift_top) begin
                        r_state <= c_ROUND;
                    end
                end
                c_ROUND: begin
                    if (r_zero) begin
                        out       <= {r_sign, {(W-1){1'b0}}};
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                    end else begin
                        out       <= {r_sign, w_efin[BYTE-1:0], w_kfin};
                        overflow  <= w_ovf;
                        underflow <= w_unf;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fmul_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_fmul_seq
// Brief    : Directed vectors with a queue scoreboard for fmul_seq.
// Revision : 1.0
// ============================================================================
module tb_fmul_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [30:0] in1;
    logic [30:0] in2;
    logic [30:0] out;
    logic        busy;
    logic        done;
    logic        overflow;
    logic        underflow;

    int total;
    int bad;
    int cyc;

    typedef struct {
        logic [30:0] o;
        logic        ov;
        logic        un;
        int          lat;
        int          t0;
        string       name;
    } exp_t;

    exp_t q[$];

    fmul_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .out       (out),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [30:0] mk(input logic s, input logic [5:0] e, input logic [23:0] f);
        return {s, e, f};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: compares every done pulse against the oldest expectation.
    always @(negedge clk) begin
        if (done) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got out=%0h expected no done", out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.name, "_out"}, 64'(out), 64'(e.o));
                chk({e.name, "_ovf"}, 64'(overflow), 64'(e.ov));
                chk({e.name, "_unf"}, 64'(underflow), 64'(e.un));
                chk({e.name, "_lat"}, 64'(cyc - e.t0), 64'(e.lat));
            end
        end
    end

    // Called at a negedge; start is presented for exactly one edge.
    task automatic issue(input string name, input logic [30:0] a, input logic [30:0] b,
                         input logic [30:0] eo, input logic eov, input logic eun,
                         input int lat, input bit push);
        exp_t e;
        in1   = a;
        in2   = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) begin
            e.o    = eo;
            e.ov   = eov;
            e.un   = eun;
            e.lat  = lat;
            e.t0   = cyc;
            e.name = name;
            q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) return;
        end
        total++;
        bad++;
        $display("FAIL %s_timeout: got no done expected done within 40 cycles", name);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        start = 1'b0;
        in1   = '0;
        in2   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out",  64'(out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf",  64'(overflow), 64'd0);
        chk("rst_unf",  64'(underflow), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue("norm1", mk(0, 33, 24'o01000000), mk(0, 33, 24'o01000000),
              mk(0, 33, 24'o01000000), 0, 0, 10, 1);
        chk("busy_high", 64'(busy), 64'd1);
        wait_done("norm1");
        // Back-to-back starts land in the done cycle.
        issue("tie_even", mk(0, 32, 24'o40000000), mk(1, 32, 24'o40000001),
              mk(1, 32, 24'o20000000), 0, 0, 9, 1);
        wait_done("tie_even");
        issue("tie_up", mk(0, 32, 24'o40000000), mk(0, 32, 24'o40000003),
              mk(0, 32, 24'o20000002), 0, 0, 9, 1);
        wait_done("tie_up");
        issue("norm7", mk(0, 40, 24'o00000001), mk(1, 40, 24'o00000001),
              mk(1, 41, 24'o01000000), 0, 0, 16, 1);
        wait_done("norm7");
        issue("ovf", mk(0, 63, 24'o40000000), mk(0, 63, 24'o40000000),
              mk(0, 30, 24'o20000000), 1, 0, 9, 1);
        wait_done("ovf");
        issue("unf", mk(0, 0, 24'o40000000), mk(0, 0, 24'o40000000),
              mk(0, 32, 24'o20000000), 0, 1, 9, 1);
        wait_done("unf");
        issue("zero", mk(1, 40, 24'o00000000), mk(0, 35, 24'o12345670),
              mk(1, 0, 24'o00000000), 0, 0, 9, 1);
        wait_done("zero");
        issue("plain", mk(1, 34, 24'o70000000), mk(1, 30, 24'o50000000),
              mk(0, 32, 24'o43000000), 0, 0, 9, 1);
        wait_done("plain");

        // A start pulse during MUL must not disturb the running operation.
        issue("ign", mk(1, 34, 24'o70000000), mk(1, 30, 24'o50000000),
              mk(0, 32, 24'o43000000), 0, 0, 9, 1);
        repeat (2) @(negedge clk);
        in1   = mk(0, 63, 24'o40000000);
        in2   = mk(1, 63, 24'o40000000);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ign");
        repeat (12) @(negedge clk);
        chk("ign_idle_busy", 64'(busy), 64'd0);

        // Reset in the middle of MUL aborts without a done pulse.
        issue("abort", mk(0, 33, 24'o01000000), mk(0, 33, 24'o01000000), '0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_out",  64'(out), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);

        issue("recover", mk(0, 33, 24'o01000000), mk(0, 33, 24'o01000000),
              mk(0, 33, 24'o01000000), 0, 0, 10, 1);
        wait_done("recover");
        @(negedge clk);
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fmul_seq.md
# fmul_seq

Parametrised sequential floating-point multiplier for MIX-format words: sign, excess-2^(BYTE-1) exponent of one byte, and an NB-byte fraction. It generalises the fixed 6-bit/4-byte digit-serial multiplier in several ways:
- Byte width, fraction length and digit width are parameters.
- It has reset and a busy/done handshake.
- It fully normalises unnormalised operands, one byte per cycle.
- It returns an exact zero result.
- It reports exponent underflow separately from overflow.

It sits in the execution unit behind the FMUL opcode decode.

## Interface
- BYTE, 6, bits per byte; exponent field width; bias Q = 2^(BYTE-1).
- NB, 4, fraction bytes; M = NB*BYTE fraction bits.
- DIGIT, 3, multiplier bits retired per cycle; M mod DIGIT must be 0; CYC = M/DIGIT.
- W (derived), 1+BYTE+M, word width (31 with defaults).

- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  operation request; accepted only when busy=0.
- in1  in  W  {sign, exp[BYTE], frac[M]}; sampled on the accepting edge.
- in2  in  W  same format as in1; sampled on the same edge as in1.
- out  out  W  result; held from done until the next accepted start.
- busy  out  1  high from the accepting edge until done.
- done  out  1  one-cycle pulse when out and the flags are valid.
- overflow  out  1  exponent above 2^BYTE-1; valid with out.
- underflow  out  1  exponent below 0; valid with out.

## Operation
State machine: IDLE -> MUL -> NORM -> ROUND -> IDLE.

- **Reset** (rst_n=0 at an edge; wins over everything, including mid-operation):
  - state goes to IDLE.
  - out, busy, done, overflow and underflow all go to 0.
- **IDLE**:
  - start=1 latches the operands.
  - sign = s1^s2, computed for every result including zero.
  - E = e1+e2-Q, held signed in BYTE+2 bits.
  - product register P (2M bits) is cleared.
  - busy goes to 1 and state goes to MUL.
- **MUL** (exactly CYC cycles):
  - Each cycle: P <= (P << DIGIT) + digit*frac2.
  - The digit is the top DIGIT bits of a left-shifting copy of frac1.
- **NORM**:
  - If P==0, go straight to ROUND with the zero flag set; no shift cycles.
  - Otherwise, while the top byte P[2M-1 : 2M-BYTE] == 0: one cycle per shift, P <= P << BYTE and E <= E-1.
  - Leave NORM when the top byte is nonzero. At most 2NB-1 shifts.
- **ROUND**: one cycle, which registers out, the flags and done.
  - Kept part K = P[2M-1:M], guard g = P[M-1], sticky s = |P[M-2:0].
  - Round half to even: round up iff g & (s | K[0]).
  - If rounding carries out of K, set K = carry-1 followed by the top M-BYTE bits of the carried sum (shift right one byte), and E <= E+1.
  - Zero result: out = {sign, 0, 0}; overflow=underflow=0.
  - Otherwise:
    - overflow = (E > 2^BYTE-1).
    - underflow = (E < 0).
    - out = {sign, E[BYTE-1:0], K}; the exponent field wraps modulo 2^BYTE on either flag.
  - busy goes to 0 and state goes to IDLE.
- **start while busy**: ignored; operands are not sampled.
- **start in the cycle done=1**: accepted, since busy is already 0.

## Timing
- Start sampled at edge T0.
- done=1 in the cycle after edge T0+CYC+k+1, where k = number of NORM shifts.
- Latency with defaults: 9 cycles for normalised-product or zero results (k=0), 10 for k=1.
- busy=1 for exactly CYC+k+1 cycles.
- out and the flags change only at the ROUND edge or at reset.

## Test plan
- **Normalised operands, one normalising shift.**
  - Stimulus: in1=in2=(s0,e33,f=0o01000000).
  - Response: k=1, done 10 cycles after start, out=(s0,e33,0o01000000), flags 0.
- **Tie, no round-up.**
  - Stimulus: (s0,e32,0o40000000) × (s1,e32,0o40000001).
  - Response: tie with even kept LSB, out=(s1,e32,0o20000000), latency 9.
- **Tie, round-up.**
  - Stimulus: (s0,e32,0o40000000) × (s0,e32,0o40000003).
  - Response: out=(s0,e32,0o20000002).
- **Multi-byte normalisation.**
  - Stimulus: (s0,e40,0o00000001) × (s1,e40,0o00000001).
  - Response: k=7, out=(s1,e41,0o01000000), done 16 cycles after start.
- **Exponent flags.**
  - Overflow: (e63,0o40000000)² -> overflow=1, out exp field 30, frac 0o20000000.
  - Underflow: (e0,0o40000000)² -> underflow=1, out exp field 32.
- **Control.**
  - Zero operand: in1 frac=0, s1=1, s2=0 -> out=(s1,e0,0), flags 0, latency 9.
  - start pulsed while busy: ignored.
  - rst_n low mid-MUL: next cycle busy=0, out=0, no done pulse.
